// File: rtl/reflet_timer_pkg.sv
// reflet_timer_pkg: register map, CTRL bit positions and state type shared by the interval timer
package reflet_timer_pkg;
  localparam int WIN_SIZE = 8;
  typedef logic [2:0] reg_off_t;
  localparam reg_off_t OFF_CTRL     = 3'd0;
  localparam reg_off_t OFF_PRESC    = 3'd1;
  localparam reg_off_t OFF_RELOAD_L = 3'd2;
  localparam reg_off_t OFF_RELOAD_H = 3'd3;
  localparam reg_off_t OFF_COUNT_L  = 3'd4;
  localparam reg_off_t OFF_COUNT_H  = 3'd5;
  localparam reg_off_t OFF_STATUS   = 3'd6;
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_CLR  = 2;
  typedef enum logic {IDLE, RUNNING} state_e;
endpackage

// File: rtl/reflet_interval_timer_if.sv
// reflet_interval_timer_if: byte-wide system bus into the timer register window
interface reflet_interval_timer_if #(parameter int base_addr_size = 16);
  logic enable;
  logic [base_addr_size-1:0] addr;
  logic write_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  modport master (output enable, addr, write_en, data_in, input data_out);
  modport slave (input enable, addr, write_en, data_in, output data_out);
endinterface

// File: rtl/reflet_prescaler.sv
// reflet_prescaler: divides clk by presc+1 while running; clear restarts the division
module reflet_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] presc,
  input  logic       clear,
  output logic       tick
);
  logic [7:0] pcnt_q, pcnt_d;
  always_comb begin
    tick = run && !clear && pcnt_q == presc;
    pcnt_d = clear ? '0 : !run ? pcnt_q : tick ? '0 : pcnt_q + 8'd1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
endmodule

// File: rtl/reflet_interval_timer.sv
// reflet_interval_timer: memory-mapped 16-bit interval timer with prescaler and expiry interrupt
module reflet_interval_timer
  import reflet_timer_pkg::*;
#(
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF20
) (
  input  logic clk,
  input  logic reset,
  reflet_interval_timer_if.slave bus,
  output logic timer_int
);
  state_e state_q, state_d;
  logic auto_q, auto_d, status_q, status_d, int_q, int_d;
  logic [7:0] presc_q, presc_d, shadow_q, shadow_d;
  logic [15:0] reload_q, reload_d, cnt_q, cnt_d;
  logic [base_addr_size-1:0] diff;
  reg_off_t off;
  logic sel, wr, wr_ctrl, clr, presc_wr, tick, expire;
  always_comb begin
    diff = bus.addr - base_addr;
    off = diff[2:0];
    sel = bus.enable && bus.addr >= base_addr && diff < base_addr_size'(WIN_SIZE);
    wr = sel && bus.write_en;
    wr_ctrl = wr && off == OFF_CTRL;
    clr = wr_ctrl && bus.data_in[CTRL_CLR];
    presc_wr = wr && off == OFF_PRESC;
  end
  reflet_prescaler u_presc (
    .clk(clk),
    .reset(reset),
    .run(state_q == RUNNING),
    .presc(presc_q),
    .clear(clr || presc_wr),
    .tick(tick)
  );
  // tick is already suppressed by CLR, so a clear never produces an expiry
  always_comb begin
    expire = tick && cnt_q == reload_q;
    auto_d = wr_ctrl ? bus.data_in[CTRL_AUTO] : auto_q;
    state_d = expire && !auto_d ? IDLE : wr_ctrl ? (bus.data_in[CTRL_RUN] ? RUNNING : IDLE) : state_q;
    presc_d = presc_wr ? bus.data_in : presc_q;
    reload_d = {wr && off == OFF_RELOAD_H ? bus.data_in : reload_q[15:8],
                wr && off == OFF_RELOAD_L ? bus.data_in : reload_q[7:0]};
    cnt_d = clr || expire ? '0 : tick ? cnt_q + 16'd1 : cnt_q;
    status_d = expire || (status_q && !(wr && off == OFF_STATUS && bus.data_in[0]));
    shadow_d = sel && !bus.write_en && off == OFF_COUNT_L ? cnt_q[15:8] : shadow_q;
    int_d = expire;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      auto_q <= 1'b0;
      status_q <= 1'b0;
      int_q <= 1'b0;
      presc_q <= '0;
      shadow_q <= '0;
      reload_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      auto_q <= auto_d;
      status_q <= status_d;
      int_q <= int_d;
      presc_q <= presc_d;
      shadow_q <= shadow_d;
      reload_q <= reload_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    bus.data_out = '0;
    if (sel)
      case (off)
        OFF_CTRL:     bus.data_out = {6'd0, auto_q, state_q == RUNNING};
        OFF_PRESC:    bus.data_out = presc_q;
        OFF_RELOAD_L: bus.data_out = reload_q[7:0];
        OFF_RELOAD_H: bus.data_out = reload_q[15:8];
        OFF_COUNT_L:  bus.data_out = cnt_q[7:0];
        OFF_COUNT_H:  bus.data_out = shadow_q;
        OFF_STATUS:   bus.data_out = {7'd0, status_q};
        default:      bus.data_out = '0;
      endcase
  end
  assign timer_int = int_q;
endmodule
